// File: rtl/ahb_rr_arbiter.sv
// Round-robin arbiter serialising single NONSEQ transfers from NUM_MASTERS AHB-Lite masters
// onto one slave port; the response is returned to the granted master. All outputs are flops.
module ahb_rr_arbiter #(
  parameter int unsigned NUM_MASTERS = 4,
  localparam int unsigned GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                        hclk,
  input  logic                        hresetn,
  input  logic [2*NUM_MASTERS-1:0]    htrans_m,
  input  logic [32*NUM_MASTERS-1:0]   haddr_m,
  input  logic [3*NUM_MASTERS-1:0]    hsize_m,
  input  logic [NUM_MASTERS-1:0]      hwrite_m,
  input  logic [32*NUM_MASTERS-1:0]   hwdata_m,
  output logic [32*NUM_MASTERS-1:0]   hrdata_m,
  output logic [NUM_MASTERS-1:0]      hready_m,
  output logic [NUM_MASTERS-1:0]      hresp_m,
  output logic                        hsel_s,
  output logic [1:0]                  htrans_s,
  output logic [31:0]                 haddr_s,
  output logic [2:0]                  hsize_s,
  output logic                        hwrite_s,
  output logic [31:0]                 hwdata_s,
  input  logic [31:0]                 hrdata_s,
  input  logic                        hready_s,
  input  logic                        hresp_s,
  output logic [GW-1:0]               hmaster
);

  typedef enum logic [1:0] {StIdle, StAddr, StData, StResp} state_e;

  localparam logic [1:0] TransIdle   = 2'b00;
  localparam logic [1:0] TransNonseq = 2'b10;

  state_e                    r_state;
  logic [GW-1:0]             r_last;
  logic [GW-1:0]             r_grant;
  logic                      r_hsel;
  logic [1:0]                r_htrans;
  logic [31:0]               r_haddr;
  logic [2:0]                r_hsize;
  logic                      r_hwrite;
  logic [31:0]               r_hwdata;
  logic [31:0]               r_wdata;
  logic [32*NUM_MASTERS-1:0] r_hrdata_m;
  logic [NUM_MASTERS-1:0]    r_hready_m;
  logic [NUM_MASTERS-1:0]    r_hresp_m;

  logic [NUM_MASTERS-1:0]    w_pending;
  logic                      w_any;
  logic [GW-1:0]             w_winner;
  logic [31:0]               w_addr;
  logic [2:0]                w_size;
  logic                      w_write;
  logic [31:0]               w_wdata;
  int unsigned               w_dist;
  int unsigned               w_best;

  // Winner is the pending master at the smallest rotated distance past the last grant.
  always_comb begin
    w_pending = '0;
    w_best    = NUM_MASTERS;
    w_dist    = 0;
    w_winner  = '0;
    w_addr    = '0;
    w_size    = '0;
    w_write   = 1'b0;
    w_wdata   = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      w_pending[i] = (htrans_m[2*i +: 2] == TransNonseq);
      w_dist = (unsigned'(i) + 2 * NUM_MASTERS - 1 - 32'(r_last)) % NUM_MASTERS;
      if (w_pending[i] && (w_dist < w_best)) begin
        w_best   = w_dist;
        w_winner = GW'(i);
        w_addr   = haddr_m[32*i +: 32];
        w_size   = hsize_m[3*i +: 3];
        w_write  = hwrite_m[i];
        w_wdata  = hwdata_m[32*i +: 32];
      end
    end
  end

  assign w_any = |w_pending;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_state    <= StIdle;
      r_last     <= GW'(NUM_MASTERS - 1);
      r_grant    <= '0;
      r_hsel     <= 1'b0;
      r_htrans   <= TransIdle;
      r_haddr    <= '0;
      r_hsize    <= '0;
      r_hwrite   <= 1'b0;
      r_hwdata   <= '0;
      r_wdata    <= '0;
      r_hrdata_m <= '0;
      r_hready_m <= '0;
      r_hresp_m  <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_any) begin
            r_grant  <= w_winner;
            r_haddr  <= w_addr;
            r_hsize  <= w_size;
            r_hwrite <= w_write;
            r_wdata  <= w_wdata;
            r_hsel   <= 1'b1;
            r_htrans <= TransNonseq;
            r_state  <= StAddr;
          end
        end
        StAddr: begin
          r_hsel   <= 1'b0;
          r_htrans <= TransIdle;
          r_hwdata <= r_wdata;
          r_state  <= StData;
        end
        StData: begin
          if (hready_s) begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
              if (r_grant == GW'(i)) begin
                r_hready_m[i]          <= 1'b1;
                r_hrdata_m[32*i +: 32] <= hrdata_s;
                r_hresp_m[i]           <= hresp_s;
              end
            end
            r_state <= StResp;
          end
        end
        StResp: begin
          r_hready_m <= '0;
          r_last     <= r_grant;
          r_state    <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign hsel_s   = r_hsel;
  assign htrans_s = r_htrans;
  assign haddr_s  = r_haddr;
  assign hsize_s  = r_hsize;
  assign hwrite_s = r_hwrite;
  assign hwdata_s = r_hwdata;
  assign hrdata_m = r_hrdata_m;
  assign hready_m = r_hready_m;
  assign hresp_m  = r_hresp_m;
  assign hmaster  = r_grant;

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// Scoreboard bench for ahb_rr_arbiter: a transaction-level round-robin model predicts each
// grant, slave address phase and completion; slave and completion monitors check them.
module tb_ahb_rr_arbiter;

  localparam int N = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  size;
    logic        write;
    logic [31:0] wdata;
  } req_t;

  typedef struct packed {
    int          m;
    logic [31:0] addr;
    logic [2:0]  size;
    logic        write;
    logic [31:0] wdata;
    int          waits;
    int          addr_cyc;
    int          done_cyc;
  } xfer_t;

  logic              hclk;
  logic              hresetn;
  logic [2*N-1:0]    htrans_m;
  logic [32*N-1:0]   haddr_m;
  logic [3*N-1:0]    hsize_m;
  logic [N-1:0]      hwrite_m;
  logic [32*N-1:0]   hwdata_m;
  logic [32*N-1:0]   hrdata_m;
  logic [N-1:0]      hready_m;
  logic [N-1:0]      hresp_m;
  logic              hsel_s;
  logic [1:0]        htrans_s;
  logic [31:0]       haddr_s;
  logic [2:0]        hsize_s;
  logic              hwrite_s;
  logic [31:0]       hwdata_s;
  logic [31:0]       hrdata_s;
  logic              hready_s;
  logic              hresp_s;
  logic [1:0]        hmaster;

  ahb_rr_arbiter #(.NUM_MASTERS(N)) dut (
    .hclk     (hclk),
    .hresetn  (hresetn),
    .htrans_m (htrans_m),
    .haddr_m  (haddr_m),
    .hsize_m  (hsize_m),
    .hwrite_m (hwrite_m),
    .hwdata_m (hwdata_m),
    .hrdata_m (hrdata_m),
    .hready_m (hready_m),
    .hresp_m  (hresp_m),
    .hsel_s   (hsel_s),
    .htrans_s (htrans_s),
    .haddr_s  (haddr_s),
    .hsize_s  (hsize_s),
    .hwrite_s (hwrite_s),
    .hwdata_s (hwdata_s),
    .hrdata_s (hrdata_s),
    .hready_s (hready_s),
    .hresp_s  (hresp_s),
    .hmaster  (hmaster)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  req_t  req_q[N][$];
  xfer_t aq[$];
  xfer_t cq[$];
  logic [N-1:0]    done;
  logic [32*N-1:0] sh_rdata;
  logic [N-1:0]    sh_resp;
  int m_last;
  int m_free_at;
  int wait_mode;
  bit gen_en;

  initial begin
    hclk = 1'b0;
    forever #5 hclk = ~hclk;
  end

  initial forever begin
    @(posedge hclk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] slave_rdata(input logic [31:0] a);
    if (a == 32'h0000_0040) return 32'hDEAD_BEEF;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  function automatic logic slave_resp(input logic [31:0] a);
    return a[11:8] == 4'hE;
  endfunction

  function automatic void push(input int m, input logic [31:0] a, input logic [2:0] sz,
                               input logic wr, input logic [31:0] wd);
    req_t r;
    r.addr = a; r.size = sz; r.write = wr; r.wdata = wd;
    req_q[m].push_back(r);
  endfunction

  function automatic bit busy();
    bit b = (cq.size() != 0);
    for (int i = 0; i < N; i++) if (req_q[i].size() != 0) b = 1'b1;
    return b;
  endfunction

  // Pending masters present NONSEQ; idle masters present IDLE/BUSY/SEQ noise.
  task automatic drive_all();
    for (int i = 0; i < N; i++) begin
      if (req_q[i].size() != 0) begin
        htrans_m[2*i +: 2]  = 2'b10;
        haddr_m[32*i +: 32] = req_q[i][0].addr;
        hsize_m[3*i +: 3]   = req_q[i][0].size;
        hwrite_m[i]         = req_q[i][0].write;
        hwdata_m[32*i +: 32] = req_q[i][0].wdata;
      end else begin
        case ($urandom_range(0, 2))
          0:       htrans_m[2*i +: 2] = 2'b00;
          1:       htrans_m[2*i +: 2] = 2'b01;
          default: htrans_m[2*i +: 2] = 2'b11;
        endcase
        haddr_m[32*i +: 32]  = $urandom;
        hsize_m[3*i +: 3]    = 3'($urandom_range(0, 7));
        hwrite_m[i]          = 1'($urandom_range(0, 1));
        hwdata_m[32*i +: 32] = $urandom;
      end
    end
  endtask

  task automatic step();
    @(posedge hclk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (done[i]) begin
        if (req_q[i].size() != 0) void'(req_q[i].pop_front());
        done[i] = 1'b0;
      end
      if (gen_en && req_q[i].size() == 0 && $urandom_range(0, 3) == 0)
        push(i, $urandom, 3'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), $urandom);
    end
    drive_all();
  endtask

  task automatic drain();
    int n = 0;
    while (busy() && n < 300) begin
      step();
      n++;
    end
    if (busy()) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: transfers still outstanding=%0d required 0", cq.size());
      cq.delete();
      aq.delete();
      for (int i = 0; i < N; i++) req_q[i].delete();
    end
    repeat (2) step();
  endtask

  // Reference model: in a free cycle, grant the first pending master after the last grant.
  initial begin : model
    xfer_t t;
    int idx;
    forever begin
      @(negedge hclk);
      if (hresetn && cyc >= m_free_at) begin
        idx = -1;
        for (int k = 1; k <= N; k++)
          if (idx < 0 && req_q[(m_last + k) % N].size() != 0) idx = (m_last + k) % N;
        if (idx >= 0) begin
          t.m        = idx;
          t.addr     = req_q[idx][0].addr;
          t.size     = req_q[idx][0].size;
          t.write    = req_q[idx][0].write;
          t.wdata    = req_q[idx][0].wdata;
          t.waits    = (wait_mode < 0) ? $urandom_range(0, 3) : wait_mode;
          t.addr_cyc = cyc + 1;
          t.done_cyc = cyc + 3 + t.waits;
          m_free_at  = cyc + 4 + t.waits;
          m_last     = idx;
          aq.push_back(t);
          cq.push_back(t);
        end
      end
    end
  end

  // Slave BFM: checks the address/data phase and answers after the model's wait count.
  initial begin : slave
    xfer_t t;
    hready_s = 1'b0;
    hrdata_s = '0;
    hresp_s  = 1'b0;
    forever begin
      @(negedge hclk);
      if (hresetn && hsel_s) begin
        chk("htrans_s_addr", htrans_s, 2'b10);
        if (aq.size() == 0) begin
          chk("unexpected_hsel_s", hsel_s, 1'b0);
        end else begin
          t = aq.pop_front();
          chk("addr_phase_cycle", cyc, t.addr_cyc);
          chk("haddr_s", haddr_s, t.addr);
          chk("hsize_s", hsize_s, t.size);
          chk("hwrite_s", hwrite_s, t.write);
          chk("hmaster_addr", hmaster, t.m);
          for (int w = 0; w <= t.waits; w++) begin
            @(posedge hclk);
            #1;
            if (!hresetn) break;
            hready_s = (w == t.waits);
            hrdata_s = hready_s ? slave_rdata(t.addr) : $urandom;
            hresp_s  = hready_s ? slave_resp(t.addr) : 1'($urandom_range(0, 1));
            @(negedge hclk);
            if (!hresetn) break;
            chk("data_phase_sel_trans", {hsel_s, htrans_s}, 3'b000);
            chk("hwdata_s", hwdata_s, t.wdata);
          end
          @(posedge hclk);
          #1;
          hready_s = 1'($urandom_range(0, 1));
          hrdata_s = $urandom;
          hresp_s  = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  // Completion monitor.
  initial begin : monitor
    xfer_t e;
    forever begin
      @(negedge hclk);
      if (hresetn) begin
        if (hready_m != '0) begin
          for (int i = 0; i < N; i++) if (hready_m[i]) done[i] = 1'b1;
          if (cq.size() == 0) begin
            chk("unexpected_hready_m", hready_m, '0);
          end else begin
            e = cq.pop_front();
            chk("hready_m_master", hready_m, 128'(1) << e.m);
            chk("completion_cycle", cyc, e.done_cyc);
            chk("hrdata_m_slice", hrdata_m[32*e.m +: 32], slave_rdata(e.addr));
            chk("hresp_m_bit", hresp_m[e.m], slave_resp(e.addr));
            chk("hmaster_resp", hmaster, e.m);
            sh_rdata[32*e.m +: 32] = slave_rdata(e.addr);
            sh_resp[e.m]           = slave_resp(e.addr);
            chk("hrdata_m_hold", hrdata_m, sh_rdata);
            chk("hresp_m_hold", hresp_m, sh_resp);
          end
        end else if (cq.size() != 0 && cyc > cq[0].done_cyc) begin
          chk("missing_hready_m", hready_m, 128'(1) << cq[0].m);
          void'(cq.pop_front());
        end
      end
    end
  end

  task automatic release_reset();
    step();
    hresetn   = 1'b1;
    m_last    = N - 1;
    m_free_at = cyc;
  endtask

  initial begin : main
    int k;
    hresetn   = 1'b0;
    gen_en    = 1'b0;
    wait_mode = 0;
    m_last    = N - 1;
    m_free_at = 0;
    done      = '0;
    sh_rdata  = '0;
    sh_resp   = '0;
    htrans_m  = '0;
    haddr_m   = '0;
    hsize_m   = '0;
    hwrite_m  = '0;
    hwdata_m  = '0;
    #2;
    chk("reset_outputs_zero", |{hrdata_m, hready_m, hresp_m, hsel_s, htrans_s, haddr_s,
                                hsize_s, hwrite_s, hwdata_s, hmaster}, 1'b0);

    // All four masters pending from reset; master 0 twice -> grants 0,1,2,3,0.
    push(0, 32'h0000_1000, 3'd2, 1'b0, 32'h0);
    push(0, 32'h0000_1004, 3'd2, 1'b1, 32'hCAFE_0000);
    push(1, 32'h0000_2000, 3'd1, 1'b1, 32'h1111_1111);
    push(2, 32'h0000_3000, 3'd0, 1'b0, 32'h0);
    push(3, 32'h0000_4000, 3'd2, 1'b1, 32'h3333_3333);
    drive_all();
    step();
    release_reset();
    drain();

    // Single zero-wait read from master 1.
    push(1, 32'h0000_0040, 3'd2, 1'b0, 32'h0);
    drive_all();
    drain();

    // Master 2 write with two slave wait states.
    wait_mode = 2;
    push(2, 32'h0000_0100, 3'd2, 1'b1, 32'h1234_5678);
    drive_all();
    drain();

    // Error response followed by an OK response on the same master.
    wait_mode = 0;
    push(3, 32'h0000_0E00, 3'd2, 1'b0, 32'h0);
    drive_all();
    drain();
    push(3, 32'h0000_0200, 3'd2, 1'b0, 32'h0);
    drive_all();
    drain();

    // Last grant 2, then masters 0 and 2 pending together -> 0 wraps ahead of 2.
    push(2, 32'h0000_0500, 3'd2, 1'b0, 32'h0);
    drive_all();
    drain();
    push(0, 32'h0000_0600, 3'd2, 1'b1, 32'hAAAA_5555);
    push(2, 32'h0000_0700, 3'd2, 1'b0, 32'h0);
    drive_all();
    drain();

    // Randomised traffic with random slave waits.
    gen_en    = 1'b1;
    wait_mode = -1;
    repeat (3000) step();
    gen_en = 1'b0;
    drain();

    // Reset asserted mid-DATA while the slave stalls.
    wait_mode = 10;
    push(2, 32'h0000_0300, 3'd2, 1'b0, 32'h0);
    drive_all();
    k = 0;
    while (k < 40) begin
      @(negedge hclk);
      if (cq.size() != 0 && cyc >= cq[0].addr_cyc + 1) break;
      k++;
    end
    if (k >= 40) begin
      checks++;
      errors++;
      $display("FAIL reach_data_phase: no address phase seen within 40 cycles, required one");
    end
    #2;
    hresetn = 1'b0;
    #1;
    chk("reset_mid_outputs_zero", |{hrdata_m, hready_m, hresp_m, hsel_s, htrans_s, haddr_s,
                                    hsize_s, hwrite_s, hwdata_s, hmaster}, 1'b0);
    aq.delete();
    cq.delete();
    done      = '0;
    sh_rdata  = '0;
    sh_resp   = '0;
    wait_mode = 0;
    push(0, 32'h0000_0800, 3'd2, 1'b0, 32'h0);
    drive_all();
    step();
    release_reset();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
